// File: rtl/axis_arb_pkg.sv
// Shared types and widths for the packet round-robin AXI-Stream arbiter.
package axis_arb_pkg;

    localparam int DATA_W = 1024;
    localparam int KEEP_W = 128;
    localparam int CNT_W  = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/axis_pkt_rr_arbiter_rr_pick.sv
// rr_pick: combinational search for the first set request at or after ptr,
// wrapping modulo NUM_SRC.
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic               found,
    output logic [SRC_W-1:0]   idx
);

    logic [SRC_W-1:0] sel;

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        sel   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            sel = SRC_W'((int'(ptr) + i) % NUM_SRC);
            if (req[sel]) begin
                found = 1'b1;
                idx   = sel;
            end
        end
    end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter feeding one registered AXI-Stream slice.
// Optional per-source packet counters are enabled with ARB_PKT_COUNT_EN.
module axis_pkt_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_SRC-1:0]               in_valid,
    output logic [NUM_SRC-1:0]               in_ready,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]   in_data,
    input  logic [NUM_SRC-1:0][KEEP_W-1:0]   in_keep,
    input  logic [NUM_SRC-1:0]               in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic [KEEP_W-1:0]                out_keep,
    output logic                             out_last,
    output logic [SRC_W-1:0]                 out_src_id,
    output logic                             busy
`ifdef ARB_PKT_COUNT_EN
    ,
    output logic [NUM_SRC-1:0][CNT_W-1:0]    pkt_count
`endif
);

    arb_state_t       state, state_nxt;
    logic [SRC_W-1:0] grant, rr_ptr, pick_idx, grant_inc;
    logic             pick_found, slice_open, vld_p0, last_p0;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr_pick (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign slice_open = ~out_valid | out_ready;
    assign grant_inc  = (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + SRC_W'(1);
    assign busy       = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = '0;
        vld_p0    = 1'b0;
        last_p0   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) state_nxt = LOCKED;
            end
            LOCKED: begin
                in_ready[grant] = slice_open;
                vld_p0          = in_valid[grant] & slice_open;
                last_p0         = vld_p0 & in_last[grant];
                if (last_p0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            if (state == IDLE && pick_found) grant <= pick_idx;
            if (last_p0) rr_ptr <= grant_inc;
        end
    end

    // p0 -> p1: accepted beat lands in the output slice
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            out_last   <= 1'b0;
            out_src_id <= '0;
        end else if (vld_p0) begin
            out_valid  <= 1'b1;
            out_data   <= in_data[grant];
            out_keep   <= in_keep[grant];
            out_last   <= in_last[grant];
            out_src_id <= grant;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef ARB_PKT_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) pkt_count <= '0;
        else if (last_p0) pkt_count[grant] <= pkt_count[grant] + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Randomized bench for axis_pkt_rr_arbiter with a packet-level round-robin model.
module tb_axis_pkt_rr_arbiter;
    import axis_arb_pkg::*;

    localparam int NUM_SRC = 4;
    localparam int SRC_W   = 2;

    logic                           clk = 1'b0;
    logic                           rst;
    logic [NUM_SRC-1:0]             in_valid, in_ready, in_last;
    logic [NUM_SRC-1:0][DATA_W-1:0] in_data;
    logic [NUM_SRC-1:0][KEEP_W-1:0] in_keep;
    logic                           out_valid, out_ready, out_last, busy;
    logic [DATA_W-1:0]              out_data;
    logic [KEEP_W-1:0]              out_keep;
    logic [SRC_W-1:0]               out_src_id;
`ifdef ARB_PKT_COUNT_EN
    logic [NUM_SRC-1:0][CNT_W-1:0]  pkt_count;
`endif

    always #5 clk = ~clk;

    axis_pkt_rr_arbiter #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_keep    (in_keep),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .out_src_id (out_src_id),
        .busy       (busy)
`ifdef ARB_PKT_COUNT_EN
        ,
        .pkt_count  (pkt_count)
`endif
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        int                src;
    } beat_t;

    beat_t src_q[NUM_SRC][$];
    beat_t pkt_store[NUM_SRC][$];
    beat_t exp_q[$];
    int    exp_order[$];
    int    start_cyc[NUM_SRC];
    bit    mid[NUM_SRC];
    int    checks = 0;
    int    failures = 0;

    function automatic beat_t rand_beat(input int s, input bit last);
        beat_t b;
        for (int w = 0; w < DATA_W / 32; w++) b.data[w*32 +: 32] = $urandom();
        for (int w = 0; w < KEEP_W / 32; w++) b.keep[w*32 +: 32] = $urandom();
        b.last = last;
        b.src  = s;
        return b;
    endfunction

    task automatic add_packet(input int s, input int nbeats);
        beat_t b;
        for (int k = 0; k < nbeats; k++) begin
            b = rand_beat(s, k == nbeats - 1);
            src_q[s].push_back(b);
            pkt_store[s].push_back(b);
        end
    endtask

    // Packet order when every source with pending packets is always requesting.
    task automatic model_rr_order();
        int left[NUM_SRC];
        int ptr, cand;
        bit found;
        exp_order.delete();
        ptr = 0;
        for (int s = 0; s < NUM_SRC; s++) begin
            left[s] = 0;
            for (int k = 0; k < pkt_store[s].size(); k++)
                if (pkt_store[s][k].last) left[s]++;
        end
        do begin
            found = 0;
            for (int off = 0; off < NUM_SRC; off++) begin
                cand = (ptr + off) % NUM_SRC;
                if (!found && left[cand] > 0) begin
                    found = 1;
                    exp_order.push_back(cand);
                    left[cand]--;
                    ptr = (cand + 1) % NUM_SRC;
                end
            end
        end while (found);
    endtask

    task automatic build_expected();
        beat_t b;
        int s;
        exp_q.delete();
        for (int i = 0; i < exp_order.size(); i++) begin
            s = exp_order[i];
            do begin
                b = pkt_store[s].pop_front();
                exp_q.push_back(b);
            end while (!b.last && pkt_store[s].size() > 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0; in_last = '0; in_data = '0; in_keep = '0;
        out_ready = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            src_q[s].delete();
            pkt_store[s].delete();
            start_cyc[s] = 0;
            mid[s] = 0;
        end
        exp_q.delete();
        exp_order.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // mode 0: out_ready high; mode 1: random ready and mid-packet bubbles;
    // mode 2: out_ready low for cycles 4..8.
    task automatic run_traffic(input int max_cycles, input int mode);
        int cyc, pkt_idx, g;
        bit prev_last, vb, exp_busy, acc_any, ov_b, or_b;
        logic [NUM_SRC-1:0] acc, exp_rdy;
        beat_t snap, e, acc_b;
        cyc = 0; pkt_idx = 0; prev_last = 0;
        while (exp_q.size() > 0 && cyc < max_cycles) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                vb = (src_q[s].size() > 0) && (cyc >= start_cyc[s]);
                if (vb && mid[s] && mode == 1 && $urandom_range(0, 3) == 0) vb = 0;
                in_valid[s] = vb;
                if (src_q[s].size() > 0) begin
                    in_data[s] = src_q[s][0].data;
                    in_keep[s] = src_q[s][0].keep;
                    in_last[s] = src_q[s][0].last;
                end else begin
                    in_last[s] = 1'b0;
                end
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = !(cyc >= 4 && cyc < 9);
            endcase
            #1;
            g = (pkt_idx < exp_order.size()) ? exp_order[pkt_idx] : 0;
            if (pkt_idx < exp_order.size()) begin
                exp_busy = !(cyc == 0 || prev_last);
                checks++;
                if (busy !== exp_busy) begin
                    failures++;
                    $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
                end
            end
            exp_rdy = '0;
            if (busy) exp_rdy[g] = !out_valid || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++;
                $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
            end
            acc  = in_valid & in_ready;
            ov_b = out_valid; or_b = out_ready;
            snap.data = out_data; snap.keep = out_keep; snap.last = out_last;
            snap.src  = int'(out_src_id);
            @(posedge clk); #1;
            acc_any = 0; prev_last = 0;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (acc[s] && src_q[s].size() > 0) begin
                    acc_b = src_q[s].pop_front();
                    acc_any = 1;
                    mid[s] = !acc_b.last;
                    if (acc_b.last) begin
                        prev_last = 1;
                        pkt_idx++;
                    end
                end
            end
            if (ov_b && or_b) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_beat extra beat src=%0d got_data=%h", snap.src, snap.data[63:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (snap.data !== e.data || snap.keep !== e.keep ||
                        snap.last !== e.last || snap.src != e.src) begin
                        failures++;
                        $display("FAIL out_beat got src=%0d last=%b data=%h exp src=%0d last=%b data=%h",
                                 snap.src, snap.last, snap.data[63:0], e.src, e.last, e.data[63:0]);
                    end
                end
            end
            checks++;
            if (acc_any) begin
                if (out_valid !== 1'b1 || out_data !== acc_b.data || out_keep !== acc_b.keep ||
                    out_last !== acc_b.last || out_src_id !== SRC_W'(acc_b.src)) begin
                    failures++;
                    $display("FAIL slice_load got v=%b src=%0d data=%h exp v=1 src=%0d data=%h",
                             out_valid, out_src_id, out_data[63:0], acc_b.src, acc_b.data[63:0]);
                end
            end else if (or_b) begin
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL slice_drain got out_valid=%b exp=0", out_valid);
                end
            end else begin
                if (out_valid !== ov_b || out_data !== snap.data || out_keep !== snap.keep ||
                    out_last !== snap.last || int'(out_src_id) != snap.src) begin
                    failures++;
                    $display("FAIL slice_hold got v=%b data=%h exp v=%b data=%h",
                             out_valid, out_data[63:0], ov_b, snap.data[63:0]);
                end
            end
            cyc++;
        end
        in_valid = '0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL traffic_timeout got remaining=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got v=%b last=%b busy=%b exp 0 0 0", out_valid, out_last, busy);
        end
        checks++;
        if (out_data !== '0 || out_keep !== '0 || out_src_id !== '0) begin
            failures++;
            $display("FAIL reset_data got data=%h keep=%h src=%0d exp 0", out_data[63:0], out_keep, out_src_id);
        end
        checks++;
        if (in_ready !== '0) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
    endtask

    task automatic test_single_src();
        do_reset();
        add_packet(0, 3);
        model_rr_order();
        build_expected();
        run_traffic(40, 0);
    endtask

    task automatic test_rr_order();
        do_reset();
        add_packet(0, 2);
        add_packet(0, 2);
        for (int s = 1; s < NUM_SRC; s++) add_packet(s, 2);
        model_rr_order();
        build_expected();
        run_traffic(80, 0);
    endtask

    task automatic test_no_preempt(input bit with_src3);
        do_reset();
        add_packet(2, 3);
        add_packet(1, 1);
        start_cyc[1] = 2;
        exp_order.push_back(2);
        if (with_src3) begin
            add_packet(3, 2);
            start_cyc[3] = 2;
            exp_order.push_back(3);
        end
        exp_order.push_back(1);
        build_expected();
        run_traffic(60, 0);
    endtask

    task automatic test_backpressure();
        do_reset();
        add_packet(0, 8);
        model_rr_order();
        build_expected();
        run_traffic(60, 2);
    endtask

    task automatic test_reset_mid_packet();
        beat_t b0, b1;
        int n;
        do_reset();
        b0 = rand_beat(0, 1);
        b1 = rand_beat(1, 0);
        in_data[0] = b0.data; in_keep[0] = b0.keep; in_last[0] = 1'b1;
        in_data[1] = b1.data; in_keep[1] = b1.keep; in_last[1] = 1'b0;
        in_valid = 4'b0011;
        out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready[0] && n < 10) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        while (!in_ready[1] && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (n >= 20) begin
            failures++;
            $display("FAIL rst_mid_setup got cycles=%0d exp <20", n);
        end
        @(posedge clk); #1;
        b1 = rand_beat(1, 0);
        in_data[1] = b1.data; in_keep[1] = b1.keep;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 || out_keep !== '0 ||
            out_src_id !== '0 || busy !== 1'b0 || in_ready !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs got v=%b last=%b data=%h src=%0d busy=%b rdy=%b exp all 0",
                     out_valid, out_last, out_data[63:0], out_src_id, busy, in_ready);
        end
        in_data[0] = b0.data; in_keep[0] = b0.keep; in_last[0] = 1'b1;
        in_valid = 4'b0011;
        n = 0;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        checks++;
        if (out_valid !== 1'b1 || out_src_id !== SRC_W'(0)) begin
            failures++;
            $display("FAIL rst_mid_ptr got v=%b src=%0d exp v=1 src=0", out_valid, out_src_id);
        end
        in_valid = '0;
    endtask

    task automatic test_random();
        int total;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            total = 0;
            for (int s = 0; s < NUM_SRC; s++) begin
                for (int p = $urandom_range(0, 3); p > 0; p--) begin
                    add_packet(s, $urandom_range(1, 5));
                    total++;
                end
            end
            if (total == 0) add_packet($urandom_range(0, NUM_SRC - 1), 2);
            model_rr_order();
            build_expected();
            run_traffic(2000, 1);
        end
    endtask

`ifdef ARB_PKT_COUNT_EN
    task automatic test_pkt_count();
        do_reset();
        for (int k = 0; k < 3; k++) add_packet(1, k + 1);
        model_rr_order();
        build_expected();
        run_traffic(200, 1);
        for (int s = 0; s < NUM_SRC; s++) begin
            checks++;
            if (pkt_count[s] !== CNT_W'((s == 1) ? 3 : 0)) begin
                failures++;
                $display("FAIL pkt_count[%0d] got=%0d exp=%0d", s, pkt_count[s], (s == 1) ? 3 : 0);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_src();
        test_rr_order();
        test_no_preempt(1'b0);
        test_no_preempt(1'b1);
        test_backpressure();
        test_reset_mid_packet();
        test_random();
`ifdef ARB_PKT_COUNT_EN
        test_pkt_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
